lifo_stack_param: RTL
=====================

# lifo_stack_param

Parametrised, clocked LIFO stack. It is the successor to the team's fixed 4-bit × 8 enable-strobed stack. It adds configurable width and depth, a true clock with asynchronous reset, and a registered pop output with a valid strobe. It also adds a peek path, occupancy count, an almost-full threshold, defined simultaneous push/pop semantics, and sticky error reporting. It sits between a producer/consumer pair in the datapath, for example as an expression or return-address stack.

## Interface
- WIDTH, 8, data word width in bits (≥1)
- DEPTH, 16, number of entries (≥2; need not be a power of two)
- AF_LEVEL, DEPTH-2, count at or above which almost_full asserts (1..DEPTH)
- CW (localparam), $clog2(DEPTH+1), width of count

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- push  in  1  request to write data_in on this edge
- pop  in  1  request to remove top entry on this edge
- data_in  in  WIDTH  word to push
- clr_err  in  1  synchronous clear of err_sticky
- data_out  out  WIDTH  registered popped word
- data_valid  out  1  one-cycle pulse: data_out updated by an accepted pop
- top_data  out  WIDTH  combinational peek of current top entry; 0 when empty
- count  out  CW  registered number of stored entries, 0..DEPTH
- empty  out  1  count == 0
- full  out  1  count == DEPTH
- almost_full  out  1  count ≥ AF_LEVEL
- overflow  out  1  one-cycle pulse: push rejected
- underflow  out  1  one-cycle pulse: pop rejected
- err_sticky  out  1  set by any overflow/underflow; held until clr_err or rst

## Operation
- Storage is an array mem[0..DEPTH-1]. The top entry is mem[count-1]. Memory is not reset.
- Decode per edge, where E = empty and F = full before the edge:
  - push only, !F: mem[count] ← data_in; count+1.
  - push only, F: no write; count unchanged; overflow=1.
  - pop only, !E: data_out ← mem[count-1]; data_valid=1; count-1.
  - pop only, E: data_out holds; data_valid=0; underflow=1.
  - push & pop, !E (including F): replace-top. data_out ← mem[count-1]; mem[count-1] ← data_in; data_valid=1; count unchanged; no overflow.
  - push & pop, E: pass-through. data_out ← data_in; data_valid=1; count stays 0; no underflow.
  - neither: all state holds; data_valid, overflow and underflow are 0.
- Flags empty, full and almost_full are registered. They are computed from the next value of count, so they agree with count in every cycle.
- err_sticky ← (err_sticky & !clr_err) | overflow_next | underflow_next. If an error occurs in the same cycle as clr_err, the error wins.
- Count arithmetic is done in CW bits. It can never wrap because the guards above apply.

## Timing
- Reset (async assert, release synchronised by the system): count=0, empty=1, full=0, almost_full=0 (AF_LEVEL≥1), data_out=0, data_valid=0, overflow=0, underflow=0, err_sticky=0, top_data=0.
- Push-to-peek latency is 1 clock. The pushed word appears on top_data after the edge that accepts it.
- Pop latency is 1 clock. data_out and data_valid update on the accepting edge. data_valid is high for exactly that cycle; data_out holds its value until the next accepted pop.
- Back-to-back operations every cycle are supported at full rate, with no bubbles.
- rst asserted mid-sequence clears all outputs immediately. Contents are logically discarded because count=0.
- push/pop are sampled only at the clock edge. There is no handshake back-pressure; rejection is reported via overflow/underflow.

## Test plan
- Reset then idle: all outputs at reset values; empty=1, count=0, top_data=0 for 5 cycles.
- Fill/drain with DEPTH=4, AF_LEVEL=3: push 1,2,3,4 -> count 1..4, almost_full rises at count=3, full at count=4. Then pop ×4 -> data_out 4,3,2,1, each with a 1-cycle data_valid; empty=1 after the last pop.
- Overflow/underflow: on a full stack push 9 -> overflow pulse, count=4, top_data=4, err_sticky=1. Drain, then pop -> underflow pulse, data_valid=0. Assert clr_err -> err_sticky=0 next cycle.
- Simultaneous push & pop: with stack [5,6] push 7 & pop -> data_out=6, top_data=7, count=2. On an empty stack push A & pop -> data_out=A, data_valid=1, count=0, no underflow. On a full stack -> replace-top, no overflow.
- Async reset mid-operation: after 3 pushes, assert rst between edges -> count=0 and empty=1 without a clock edge. Push 0x3C after release -> top_data=0x3C, count=1.
- Non-power-of-two DEPTH=5, WIDTH=12: push 5 words -> full; the 6th push overflows; pops return the words in reverse order; count never exceeds 5.

Source files
------------

// File: rtl/lifo_stack_param_if.sv
// Producer/consumer bundle for lifo_stack_param: push/pop requests in,
// popped word, peek, occupancy and error strobes out.
interface lifo_stack_param_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             push;
    logic             pop;
    logic [WIDTH-1:0] data_in;
    logic             clr_err;
    logic [WIDTH-1:0] data_out;
    logic             data_valid;
    logic [WIDTH-1:0] top_data;
    logic [CW-1:0]    count;
    logic             empty;
    logic             full;
    logic             almost_full;
    logic             overflow;
    logic             underflow;
    logic             err_sticky;

    modport master (
        output push, pop, data_in, clr_err,
        input  data_out, data_valid, top_data, count, empty, full,
               almost_full, overflow, underflow, err_sticky
    );

    modport slave (
        input  push, pop, data_in, clr_err,
        output data_out, data_valid, top_data, count, empty, full,
               almost_full, overflow, underflow, err_sticky
    );
endinterface

// File: rtl/lifo_stack_param.sv
// Parametrised clocked LIFO stack with registered pop output, combinational
// peek, registered occupancy flags and sticky overflow/underflow reporting.
module lifo_stack_param #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2
) (
    input  logic                clk,
    input  logic                rst,
    lifo_stack_param_if.slave   bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             data_valid_q, data_valid_d;
    logic             empty_q, empty_d;
    logic             full_q, full_d;
    logic             almost_full_q, almost_full_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             err_sticky_q, err_sticky_d;

    logic             wr_en;
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    top_idx;

    // Only meaningful when the stack is non-empty; wraps harmlessly otherwise.
    assign top_idx = AW'(count_q - CW'(1));

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        count_d      = count_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        overflow_d   = 1'b0;
        underflow_d  = 1'b0;
        wr_en        = 1'b0;
        wr_idx       = AW'(count_q);

        unique case ({bus.push, bus.pop})
            2'b10: begin
                if (full_q) begin
                    overflow_d = 1'b1;
                end else begin
                    wr_en   = 1'b1;
                    count_d = count_q + CW'(1);
                end
            end
            2'b01: begin
                if (empty_q) begin
                    underflow_d = 1'b1;
                end else begin
                    data_out_d   = mem_q[top_idx];
                    data_valid_d = 1'b1;
                    count_d      = count_q - CW'(1);
                end
            end
            2'b11: begin
                data_valid_d = 1'b1;
                if (empty_q) begin
                    data_out_d = bus.data_in;
                end else begin
                    // Replace-top: old top leaves, new word takes its slot.
                    data_out_d = mem_q[top_idx];
                    wr_en      = 1'b1;
                    wr_idx     = top_idx;
                end
            end
            default: ;
        endcase

        empty_d       = (count_d == '0);
        full_d        = (count_d == CW'(DEPTH));
        almost_full_d = (count_d >= CW'(AF_LEVEL));
        err_sticky_d  = (err_sticky_q & ~bus.clr_err) | overflow_d | underflow_d;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q       <= '0;
            data_out_q    <= '0;
            data_valid_q  <= 1'b0;
            empty_q       <= 1'b1;
            full_q        <= 1'b0;
            almost_full_q <= 1'b0;
            overflow_q    <= 1'b0;
            underflow_q   <= 1'b0;
            err_sticky_q  <= 1'b0;
        end else begin
            count_q       <= count_d;
            data_out_q    <= data_out_d;
            data_valid_q  <= data_valid_d;
            empty_q       <= empty_d;
            full_q        <= full_d;
            almost_full_q <= almost_full_d;
            overflow_q    <= overflow_d;
            underflow_q   <= underflow_d;
            err_sticky_q  <= err_sticky_d;
        end
    end

    // NOTE: storage is deliberately not reset; count_q=0 already marks every entry as dead.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= bus.data_in;
        end
    end

    assign bus.data_out    = data_out_q;
    assign bus.data_valid  = data_valid_q;
    assign bus.top_data    = empty_q ? '0 : mem_q[top_idx];
    assign bus.count       = count_q;
    assign bus.empty       = empty_q;
    assign bus.full        = full_q;
    assign bus.almost_full = almost_full_q;
    assign bus.overflow    = overflow_q;
    assign bus.underflow   = underflow_q;
    assign bus.err_sticky  = err_sticky_q;
endmodule
